// File: rtl/subtrator_serial.sv
// Bit-serial subtractor D = A - B, LSB first, one full-subtractor cell plus a borrow flop,
// wrapped in a START/BUSY/DONE handshake that also reports unsigned borrow and signed overflow.
module subtrator_serial #(
  parameter int WIDTH = 4,
  parameter int CW    = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] D,
  output logic             BORROW,
  output logic             OVERFLOW
);

  typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;

  // Returns {borrow_out, diff_bit} for a single bit position.
  function automatic logic [1:0] full_sub(input logic a, input logic b, input logic bw);
    return {(~a & b) | (~(a ^ b) & bw), a ^ b ^ bw};
  endfunction

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] work;
  logic [CW-1:0]    cnt;
  logic             bw;
  logic             a_msb;
  logic             b_msb;

  logic [1:0]       fs;
  logic [WIDTH-1:0] work_nxt;

  always_comb begin
    fs       = full_sub(sa[0], sb[0], bw);
    work_nxt = {fs[0], work[WIDTH-1:1]};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      sa       <= '0;
      sb       <= '0;
      work     <= '0;
      cnt      <= '0;
      bw       <= 1'b0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      D        <= '0;
      BORROW   <= 1'b0;
      OVERFLOW <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          DONE <= 1'b0;
          if (START) begin
            state <= SHIFT;
            sa    <= A;
            sb    <= B;
            a_msb <= A[WIDTH-1];
            b_msb <= B[WIDTH-1];
            work  <= '0;
            cnt   <= '0;
            bw    <= 1'b0;
            BUSY  <= 1'b1;
          end
        end
        SHIFT: begin
          sa   <= {1'b0, sa[WIDTH-1:1]};
          sb   <= {1'b0, sb[WIDTH-1:1]};
          work <= work_nxt;
          bw   <= fs[1];
          cnt  <= cnt + CW'(1);
          // Last bit: the freshly computed diff bit is the result MSB.
          if (cnt == CW'(WIDTH - 1)) begin
            state    <= FIN;
            D        <= work_nxt;
            BORROW   <= fs[1];
            OVERFLOW <= (a_msb != b_msb) && (fs[0] != a_msb);
            DONE     <= 1'b1;
            BUSY     <= 1'b0;
          end
        end
        FIN: begin
          state <= IDLE;
          DONE  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
          DONE  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/subtrator_serial.md
Name: subtrator_serial

Overview:
- Bit-serial subtractor: computes D = A - B one bit per clock, LSB first, using a single full-subtractor cell and a borrow flip-flop.
- It is the inverse-direction companion of the combinational 4-bit adder in the arithmetic library.
- It sits behind a start/done handshake so a controller can issue operations and collect difference, borrow and signed-overflow flags.

Parameters:
- WIDTH, 4: operand and result width in bits (legal range 2..16).
- CW, 5: counter width; must satisfy 2^CW > WIDTH.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  synchronous, active-high reset.
- START  input  1  request; sampled only in IDLE.
- A  input  WIDTH  minuend; sampled on the accepting edge only.
- B  input  WIDTH  subtrahend; sampled on the accepting edge only.
- BUSY  output  1  high while an operation is in progress (state SHIFT).
- DONE  output  1  one-cycle pulse when a result becomes valid.
- D  output  WIDTH  difference, A - B mod 2^WIDTH.
- BORROW  output  1  unsigned borrow out; 1 iff A < B.
- OVERFLOW  output  1  signed (two's-complement) overflow of A - B.

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous and active-high on RST, sampled on the rising edge of CLK.
- Reset values: state=IDLE, BUSY=0, DONE=0, D=0, BORROW=0, OVERFLOW=0, bit counter=0, internal shift registers=0, borrow flip-flop=0.
- Reset mid-operation: the operation is abandoned; on the next edge all outputs are at their reset values, and no DONE pulse is ever produced for the aborted operation.
- States: IDLE, SHIFT, FIN.
- IDLE -> SHIFT: on an edge with START=1 (the accepting edge, e0):
  - latch A into shift register SA and B into SB;
  - clear the borrow flip-flop and the counter;
  - BUSY=1 from e0 onward.
- SHIFT, at each edge e1..eWIDTH, processing bit k = counter:
  - a=SA[0], b=SB[0], bw=borrow;
  - diff bit = a^b^bw;
  - borrow_next = (~a&b) | (~(a^b)&bw);
  - diff bit is shifted into a working register from the MSB side;
  - SA and SB shift right; counter increments.
- SHIFT -> FIN: at edge eWIDTH, when the last bit (k=WIDTH-1) is processed:
  - D <= completed working register; BORROW <= final borrow;
  - OVERFLOW <= (A_msb != B_msb) && (D_msb != A_msb), using the latched operand MSBs;
  - DONE=1, BUSY=0.
- FIN -> IDLE: unconditionally on the next edge; DONE returns to 0.
- Latency: DONE is high in the cycle following edge eWIDTH, i.e. WIDTH edges after the accepting edge. Throughput is one operation per WIDTH+2 cycles.
- START handling:
  - START while BUSY=1 or in FIN is ignored, and no queuing occurs.
  - START held high continuously starts a new operation on each return to IDLE.
  - A and B may change freely after e0 without affecting the result.
- Output hold: D, BORROW and OVERFLOW update only at the FIN transition. They hold the previous result throughout a subsequent operation (stable while BUSY=1) until the next completion.
- Arithmetic: the result is exactly (A - B) mod 2^WIDTH; BORROW equals bit WIDTH of the (WIDTH+1)-bit unsigned difference.
- The counter wraps to 0 on entering SHIFT; it never exceeds WIDTH.

Test Plan:
- Reset, then A=0101, B=0011, START pulse -> DONE pulse exactly 4 edges after the accepting edge; D=0010, BORROW=0, OVERFLOW=0; BUSY high for exactly 4 cycles.
- A=0011, B=0101 -> D=1110, BORROW=1, OVERFLOW=0. Then A=1000, B=0001 -> D=0111, BORROW=0, OVERFLOW=1. Then A=0111, B=1111 -> D=1000, BORROW=1, OVERFLOW=1.
- Exhaustive sweep, nested loops i,j over 0..15 (A=i, B=j), each START waiting for DONE -> D == (i-j)&4'hF, BORROW == (i<j), OVERFLOW matches a signed reference model; print each result with $monitor-style logging.
- START pulsed while BUSY=1 with different A/B -> ignored: the first result is reported unchanged, exactly one DONE pulse, and the operands changed after e0 have no effect.
- RST asserted for one cycle at the 2nd SHIFT edge -> next cycle all outputs 0 and state IDLE, no DONE follows; a new START then completes normally (A=1111, B=0001 -> D=1110).
- START held high for 20 cycles with A=0000, B=0001 -> DONE pulses every 6 cycles, each with D=1111, BORROW=1, OVERFLOW=0.
